// File: rtl/alu_key_loader.sv
// Serial CRC-8 protected key loader feeding the locked ALU's working_key.
// Holds an all-zero key until a frame passes its CRC check, counts failed attempts and locks out after MAX_TRY.
module alu_key_loader #(
  parameter int KEY_W   = 255,
  parameter int MAX_TRY = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_start,
  input  logic             key_bit_in,
  input  logic             key_bit_valid,
  output logic [KEY_W-1:0] working_key,
  output logic             key_valid,
  output logic             key_error,
  output logic             lockout,
  output logic             busy
);

  localparam int BCNT_W = $clog2(KEY_W + 1);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam int FCNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_KEY,
    SHIFT_CRC,
    CHECK,
    LOCKED,
    ERROR,
    LOCKOUT
  } state_t;

  state_t              state, state_nxt;
  logic [KEY_W-1:0]    shadow;
  logic [KEY_W-1:0]    working_key_q;
  logic [7:0]          crc;
  logic [7:0]          rx_crc;
  logic [BCNT_W-1:0]   bit_cnt;
  logic [TCNT_W-1:0]   tmo_cnt;
  logic [FCNT_W-1:0]   fail_cnt;
  logic                shifting;
  logic                bit_acc;
  logic                tmo_hit;
  logic                last_key_bit;
  logic                last_crc_bit;
  logic                crc_ok;
  logic                fail_hit;
  logic                start_frame;
  logic                enter_err;

  // CRC-8, polynomial x^8+x^2+x+1, MSB first, one bit per call.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  assign shifting     = (state == SHIFT_KEY) || (state == SHIFT_CRC);
  assign bit_acc      = shifting && key_bit_valid;
  assign tmo_hit      = shifting && !key_bit_valid && (tmo_cnt == TCNT_W'(TIMEOUT - 1));
  assign last_key_bit = bit_acc && (state == SHIFT_KEY) && (bit_cnt == BCNT_W'(KEY_W - 1));
  assign last_crc_bit = bit_acc && (state == SHIFT_CRC) && (bit_cnt == BCNT_W'(7));
  assign crc_ok       = (rx_crc == crc);
  assign fail_hit     = (fail_cnt == FCNT_W'(MAX_TRY));

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    unique case (state)
      IDLE: begin
        if (key_start) begin
          state_nxt   = SHIFT_KEY;
          start_frame = 1'b1;
        end
      end
      SHIFT_KEY: begin
        if (tmo_hit)           state_nxt = ERROR;
        else if (last_key_bit) state_nxt = SHIFT_CRC;
      end
      SHIFT_CRC: begin
        if (tmo_hit)           state_nxt = ERROR;
        else if (last_crc_bit) state_nxt = CHECK;
      end
      CHECK:   state_nxt = crc_ok ? LOCKED : ERROR;
      LOCKED:  state_nxt = LOCKED;
      ERROR: begin
        // Lockout takes priority over a retry arriving in the same cycle.
        if (fail_hit) begin
          state_nxt = LOCKOUT;
        end else if (key_start) begin
          state_nxt   = SHIFT_KEY;
          start_frame = 1'b1;
        end
      end
      LOCKOUT: state_nxt = LOCKOUT;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_err = (state_nxt == ERROR) && (state != ERROR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Frame capture: shadow key, running CRC, received CRC, bit and idle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      crc     <= '0;
      rx_crc  <= '0;
      bit_cnt <= '0;
      tmo_cnt <= '0;
    end else if (start_frame) begin
      shadow  <= '0;
      crc     <= '0;
      rx_crc  <= '0;
      bit_cnt <= '0;
      tmo_cnt <= '0;
    end else if (bit_acc) begin
      tmo_cnt <= '0;
      if (state == SHIFT_KEY) begin
        shadow  <= {shadow[KEY_W-2:0], key_bit_in};
        crc     <= crc8_step(crc, key_bit_in);
        bit_cnt <= last_key_bit ? '0 : bit_cnt + BCNT_W'(1);
      end else begin
        rx_crc  <= {rx_crc[6:0], key_bit_in};
        bit_cnt <= bit_cnt + BCNT_W'(1);
      end
    end else if (shifting) begin
      tmo_cnt <= tmo_cnt + TCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_error <= 1'b0;
      fail_cnt  <= '0;
    end else if (enter_err) begin
      key_error <= 1'b1;
      fail_cnt  <= fail_cnt + FCNT_W'(1);
    end else if (start_frame) begin
      key_error <= 1'b0;
    end
  end

  // The only path onto working_key: a single load on a passing CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      working_key_q <= '0;
      key_valid     <= 1'b0;
    end else if ((state == CHECK) && crc_ok) begin
      working_key_q <= shadow;
      key_valid     <= 1'b1;
    end
  end

  assign working_key = working_key_q;
  assign lockout     = (state == LOCKOUT);
  assign busy        = (state == SHIFT_KEY) || (state == SHIFT_CRC) || (state == CHECK);

endmodule

// File: tb/tb_alu_key_loader.sv
// Directed bench for alu_key_loader: CRC pass/fail, lockout, timeout, gaps, key freeze and async reset.
module tb_alu_key_loader;

  localparam int KEY_W = 255;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             key_start;
  logic             key_bit_in;
  logic             key_bit_valid;
  logic [KEY_W-1:0] working_key;
  logic             key_valid;
  logic             key_error;
  logic             lockout;
  logic             busy;
  logic [3:0]       stat;

  int checks   = 0;
  int failures = 0;

  logic [KEY_W-1:0] k1, k2, k3;

  alu_key_loader #(.KEY_W(KEY_W), .MAX_TRY(3), .TIMEOUT(1024)) dut (
    .clk(clk), .rst_n(rst_n), .key_start(key_start), .key_bit_in(key_bit_in),
    .key_bit_valid(key_bit_valid), .working_key(working_key), .key_valid(key_valid),
    .key_error(key_error), .lockout(lockout), .busy(busy)
  );

  always #5 clk = ~clk;

  assign stat = {key_valid, key_error, lockout, busy};

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; key_start = 1'b0; key_bit_valid = 1'b0; key_bit_in = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic pulse_start();
    key_start = 1'b1;
    tick(1);
    key_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    key_bit_in = b; key_bit_valid = 1'b1;
    tick(1);
    key_bit_valid = 1'b0;
  endtask

  task automatic send_key_bits(input logic [KEY_W-1:0] k, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(k[i]);
  endtask

  task automatic send_crc(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) send_bit(c[i]);
  endtask

  task automatic send_frame(input logic [KEY_W-1:0] k, input logic [7:0] c);
    send_key_bits(k, KEY_W - 1, 0);
    send_crc(c);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (stat !== 4'b0000) begin failures++; $display("FAIL reset_stat got %b exp %b", stat, 4'b0000); end
    checks++; if (working_key !== '0) begin failures++; $display("FAIL reset_key got %h exp 0", working_key); end
  endtask

  task automatic test_load_ok();
    do_reset();
    pulse_start();
    checks++; if (stat !== 4'b0001) begin failures++; $display("FAIL ok_start_stat got %b exp %b", stat, 4'b0001); end
    send_frame(k1, 8'h07);
    checks++; if (stat !== 4'b0001) begin failures++; $display("FAIL ok_check_stat got %b exp %b", stat, 4'b0001); end
    checks++; if (working_key !== '0) begin failures++; $display("FAIL ok_check_key got %h exp 0", working_key); end
    tick(1);
    checks++; if (stat !== 4'b1000) begin failures++; $display("FAIL ok_stat got %b exp %b", stat, 4'b1000); end
    checks++; if (working_key !== k1) begin failures++; $display("FAIL ok_key got %h exp %h", working_key, k1); end
  endtask

  task automatic test_crc_error();
    do_reset();
    pulse_start();
    send_frame(k1, 8'h06);
    tick(1);
    checks++; if (stat !== 4'b0100) begin failures++; $display("FAIL crcerr_stat got %b exp %b", stat, 4'b0100); end
    checks++; if (working_key !== '0) begin failures++; $display("FAIL crcerr_key got %h exp 0", working_key); end
    pulse_start();
    checks++; if (stat !== 4'b0001) begin failures++; $display("FAIL retry_start_stat got %b exp %b", stat, 4'b0001); end
    send_frame(k1, 8'h07);
    tick(1);
    checks++; if (stat !== 4'b1000) begin failures++; $display("FAIL retry_stat got %b exp %b", stat, 4'b1000); end
    checks++; if (working_key !== k1) begin failures++; $display("FAIL retry_key got %h exp %h", working_key, k1); end
  endtask

  task automatic test_lockout();
    do_reset();
    for (int n = 0; n < 3; n++) begin
      pulse_start();
      send_frame(k1, 8'h00);
      tick(1);
      checks++; if (stat !== 4'b0100) begin failures++; $display("FAIL lock_try%0d_stat got %b exp %b", n, stat, 4'b0100); end
    end
    tick(1);
    checks++; if (stat !== 4'b0110) begin failures++; $display("FAIL lockout_stat got %b exp %b", stat, 4'b0110); end
    pulse_start();
    send_frame(k1, 8'h07);
    tick(2);
    checks++; if (stat !== 4'b0110) begin failures++; $display("FAIL lockout_hold_stat got %b exp %b", stat, 4'b0110); end
    checks++; if (working_key !== '0) begin failures++; $display("FAIL lockout_key got %h exp 0", working_key); end
    do_reset();
    checks++; if (stat !== 4'b0000) begin failures++; $display("FAIL lockout_rst_stat got %b exp %b", stat, 4'b0000); end
    pulse_start();
    send_frame(k1, 8'h07);
    tick(1);
    checks++; if (working_key !== k1 || stat !== 4'b1000) begin failures++; $display("FAIL lockout_reload got key=%h stat=%b exp key=%h stat=%b", working_key, stat, k1, 4'b1000); end
  endtask

  task automatic test_fail_cnt_reset();
    do_reset();
    for (int n = 0; n < 2; n++) begin
      pulse_start(); send_frame(k1, 8'h00); tick(1);
    end
    do_reset();
    for (int n = 0; n < 2; n++) begin
      pulse_start(); send_frame(k1, 8'h00); tick(1);
    end
    tick(2);
    checks++; if (stat !== 4'b0100) begin failures++; $display("FAIL failcnt_clear_stat got %b exp %b", stat, 4'b0100); end
  endtask

  task automatic test_timeout();
    do_reset();
    pulse_start();
    send_key_bits(k1, KEY_W - 1, KEY_W - 100);
    tick(1023);
    checks++; if (stat !== 4'b0001) begin failures++; $display("FAIL tmo_1023_stat got %b exp %b", stat, 4'b0001); end
    tick(1);
    checks++; if (stat !== 4'b0100) begin failures++; $display("FAIL tmo_1024_stat got %b exp %b", stat, 4'b0100); end
    do_reset();
    pulse_start();
    send_key_bits(k1, KEY_W - 1, KEY_W - 100);
    tick(1023);
    send_key_bits(k1, KEY_W - 101, 0);
    send_crc(8'h07);
    tick(1);
    checks++; if (stat !== 4'b1000 || working_key !== k1) begin failures++; $display("FAIL tmo_gap_ok got key=%h stat=%b exp key=%h stat=%b", working_key, stat, k1, 4'b1000); end
  endtask

  task automatic test_gaps_start();
    logic [KEY_W+7:0] frame;
    frame = {k3, 8'h09};
    do_reset();
    pulse_start();
    for (int i = KEY_W + 7; i >= 0; i--) begin
      repeat ($urandom_range(1, 5)) begin
        key_start = (i % 40 == 0);
        tick(1);
        key_start = 1'b0;
      end
      key_start = (i % 60 == 1);
      send_bit(frame[i]);
      key_start = 1'b0;
      if (i == 120) begin
        checks++; if (stat !== 4'b0001) begin failures++; $display("FAIL gaps_mid_stat got %b exp %b", stat, 4'b0001); end
      end
    end
    tick(1);
    checks++; if (stat !== 4'b1000) begin failures++; $display("FAIL gaps_stat got %b exp %b", stat, 4'b1000); end
    checks++; if (working_key !== k3) begin failures++; $display("FAIL gaps_key got %h exp %h", working_key, k3); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulse_start();
    send_frame(k2, 8'h0E);
    tick(1);
    checks++; if (working_key !== k2 || stat !== 4'b1000) begin failures++; $display("FAIL k2_load got key=%h stat=%b exp key=%h stat=%b", working_key, stat, k2, 4'b1000); end
    pulse_start();
    send_frame(k1, 8'h07);
    tick(2);
    checks++; if (working_key !== k2) begin failures++; $display("FAIL locked_hold_key got %h exp %h", working_key, k2); end
    checks++; if (stat !== 4'b1000) begin failures++; $display("FAIL locked_hold_stat got %b exp %b", stat, 4'b1000); end
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse_start();
    send_frame(k1, 8'h07);
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (stat !== 4'b0000 || working_key !== '0) begin failures++; $display("FAIL arst_locked got key=%h stat=%b exp 0/0000", working_key, stat); end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    pulse_start();
    send_key_bits(k1, KEY_W - 1, KEY_W - 50);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (stat !== 4'b0000) begin failures++; $display("FAIL arst_midframe got %b exp %b", stat, 4'b0000); end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    pulse_start();
    send_frame(k1, 8'h07);
    tick(1);
    checks++; if (working_key !== k1 || stat !== 4'b1000) begin failures++; $display("FAIL arst_reload got key=%h stat=%b exp key=%h stat=%b", working_key, stat, k1, 4'b1000); end
  endtask

  initial begin
    k1 = '0; k1[0] = 1'b1;
    k2 = '0; k2[1] = 1'b1;
    k3 = '0; k3[1:0] = 2'b11;
    test_reset();
    test_load_ok();
    test_crc_error();
    test_lockout();
    test_fail_cnt_reset();
    test_timeout();
    test_gaps_start();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
